// File: rtl/cam_sccb_config.sv
// -----------------------------------------------------------------------------
// cam_sccb_config
//   Configures an OV7670 sensor for RGB565 QQVGA output. On an accepted start
//   it walks a fixed 8-entry {reg, val} table. Each entry goes out as one SCCB
//   3-phase write: START, DEV_ADDR, reg, val, STOP, followed by an idle gap.
//   After the COM7 soft-reset write (12<-80) the bus stays idle for
//   RESET_WAIT_CYC cycles so the sensor can finish its internal reset.
//
//   Every bus edge falls on a quarter-period boundary.
//   QTR = CLK_HZ / (4 * SCCB_HZ) clk cycles per quarter.
//
// Optional feature (macro SCCB_ACK_CHECK_EN):
//   defined   - the 9th bit of each byte is sampled. A 1 is a NACK: the bus
//               closes with STOP, err is set and busy drops. reg_idx keeps the
//               index of the failing entry.
//   undefined - the 9th bit is ignored, sccb_sda_in is unused, err is 0.
//
// Ports:
//   clk          system clock (25 MHz VGA domain)
//   rst          synchronous active-high reset
//   start        level request, sampled only while idle
//   sccb_scl     SIO_C, push-pull
//   sccb_sda_oe  1 = pull SIO_D low, 0 = release (open drain)
//   sccb_sda_in  SIO_D pad readback
//   busy         high while the table is being sent
//   done         sticky completion flag, cleared by the next accepted start
//   err          sticky NACK flag (0 unless SCCB_ACK_CHECK_EN)
//   reg_idx      table entry in flight
// -----------------------------------------------------------------------------
module cam_sccb_config #(
  parameter int unsigned CLK_HZ         = 25_000_000,
  parameter int unsigned SCCB_HZ        = 100_000,
  parameter logic [7:0]  DEV_ADDR       = 8'h42,
  parameter int unsigned RESET_WAIT_CYC = 25_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       sccb_scl,
  output logic       sccb_sda_oe,
  input  logic       sccb_sda_in,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] reg_idx
);

  localparam int unsigned QTR = CLK_HZ / (4 * SCCB_HZ);
  localparam int unsigned CW  = (QTR > 1) ? $clog2(QTR) : 1;
  localparam int unsigned WW  = (RESET_WAIT_CYC > 1) ? $clog2(RESET_WAIT_CYC) : 1;
  localparam logic [CW-1:0] QTR_LAST  = CW'(QTR - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(RESET_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_BIT      = 3'd2,
    S_STOP     = 3'd3,
    S_GAP      = 3'd4,
    S_WAIT_RST = 3'd5,
    S_DONE     = 3'd6
`ifdef SCCB_ACK_CHECK_EN
    , S_ERR    = 3'd7
`endif
  } state_e;

  // Register table: {reg, val}, sent in index order.
  function automatic logic [15:0] cfg_entry(input logic [2:0] idx);
    logic [15:0] e;
    case (idx)
      3'd0:    e = 16'h12_80;  // COM7: soft reset
      3'd1:    e = 16'h12_04;  // COM7: RGB output
      3'd2:    e = 16'h11_00;  // CLKRC: no prescale
      3'd3:    e = 16'h0C_04;  // COM3: DCW enable (scaling)
      3'd4:    e = 16'h3E_1A;  // COM14: PCLK divide by 4, manual scaling
      3'd5:    e = 16'h40_D0;  // COM15: RGB565, full range
      3'd6:    e = 16'h72_22;  // SCALING_DCWCTR: downsample by 4
      3'd7:    e = 16'h73_F2;  // SCALING_PCLK_DIV: divide by 4
      default: e = 16'h12_80;
    endcase
    return e;
  endfunction

  state_e        state_q, state_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [2:0]    idx_q, idx_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          scl_q, scl_d;
  logic          oe_q, oe_d;

  logic          qtr_end_s;
  logic          period_end_s;
  logic          bus_state_s;
  logic          is_reset_entry_s;
  logic          ack_fail_s;
  logic [15:0]   nxt_entry_s;
  logic [7:0]    byte_val_s;
  logic          data_bit_s;

`ifdef SCCB_ACK_CHECK_EN
  logic          err_q, err_d;
  logic          nack_q, nack_d;
  assign ack_fail_s = nack_q;
  assign err        = err_q;
`else
  logic          sda_in_unused_s;
  assign sda_in_unused_s = sccb_sda_in;
  assign ack_fail_s      = 1'b0;
  assign err             = 1'b0;
`endif

  assign qtr_end_s        = (cnt_q == QTR_LAST);
  assign period_end_s     = qtr_end_s && (qtr_q == 2'd3);
  assign bus_state_s      = (state_q == S_START) || (state_q == S_BIT) ||
                            (state_q == S_STOP)  || (state_q == S_GAP);
  assign is_reset_entry_s = (cfg_entry(idx_q) == 16'h12_80);

  // Next-state, sequencing counters and status flags.
  always_comb begin
    state_d = state_q;
    qtr_d   = qtr_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef SCCB_ACK_CHECK_EN
    err_d   = err_q;
    nack_d  = nack_q;
`endif

    // Quarter timebase runs only while the bus is being driven.
    if (bus_state_s) begin
      if (qtr_end_s) begin
        cnt_d = {CW{1'b0}};
        qtr_d = qtr_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_START;
          qtr_d   = 2'd0;
          cnt_d   = {CW{1'b0}};
          bit_d   = 4'd0;
          byte_d  = 2'd0;
          idx_d   = 3'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
`ifdef SCCB_ACK_CHECK_EN
          err_d   = 1'b0;
          nack_d  = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_START: begin
        if (period_end_s) begin
          state_d = S_BIT;
          bit_d   = 4'd0;
          byte_d  = 2'd0;
        end else begin
          state_d = S_START;
        end
      end

      S_BIT: begin
`ifdef SCCB_ACK_CHECK_EN
        // Slave response is read on the last clk of q2 of the 9th bit.
        if (qtr_end_s && (qtr_q == 2'd2) && (bit_q == 4'd8)) begin
          nack_d = sccb_sda_in;
        end else begin
          nack_d = nack_q;
        end
`endif
        if (period_end_s) begin
          if (bit_q == 4'd8) begin
            bit_d = 4'd0;
            // A NACK cuts the transaction short after the current byte.
            if ((byte_q == 2'd2) || ack_fail_s) begin
              state_d = S_STOP;
            end else begin
              byte_d  = byte_q + 2'd1;
              state_d = S_BIT;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            state_d = S_BIT;
          end
        end else begin
          state_d = S_BIT;
        end
      end

      S_STOP: begin
        if (period_end_s) begin
`ifdef SCCB_ACK_CHECK_EN
          if (nack_q) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_GAP;
          end
`else
          state_d = S_GAP;
`endif
        end else begin
          state_d = S_STOP;
        end
      end

      S_GAP: begin
        if (period_end_s) begin
          if (is_reset_entry_s) begin
            state_d = S_WAIT_RST;
            wcnt_d  = {WW{1'b0}};
          end else if (idx_q == 3'd7) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_START;
          end
        end else begin
          state_d = S_GAP;
        end
      end

      S_WAIT_RST: begin
        if (wcnt_q == WAIT_LAST) begin
          wcnt_d  = {WW{1'b0}};
          idx_d   = idx_q + 3'd1;
          qtr_d   = 2'd0;
          cnt_d   = {CW{1'b0}};
          state_d = S_START;
        end else begin
          wcnt_d  = wcnt_q + WW'(1);
          state_d = S_WAIT_RST;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

`ifdef SCCB_ACK_CHECK_EN
      S_ERR: begin
        state_d = S_IDLE;
      end
`endif

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Bus pin levels are decoded from the next state, so the registered pins
  // line up exactly with the state register.
  always_comb begin
    scl_d       = 1'b1;
    oe_d        = 1'b0;
    nxt_entry_s = cfg_entry(idx_d);

    case (byte_d)
      2'd0:    byte_val_s = DEV_ADDR;
      2'd1:    byte_val_s = nxt_entry_s[15:8];
      default: byte_val_s = nxt_entry_s[7:0];
    endcase

    // Bits 0..7 are MSB first; the 9th bit leaves SDA released.
    if (bit_d < 4'd8) begin
      data_bit_s = byte_val_s[3'(4'd7 - bit_d)];
    end else begin
      data_bit_s = 1'b1;
    end

    case (state_d)
      S_START: begin
        case (qtr_d)
          2'd0:       begin scl_d = 1'b1; oe_d = 1'b0; end
          2'd1, 2'd2: begin scl_d = 1'b1; oe_d = 1'b1; end
          default:    begin scl_d = 1'b0; oe_d = 1'b1; end
        endcase
      end
      S_BIT: begin
        // Low for q0/q1, high for q2/q3.
        scl_d = qtr_d[1];
        oe_d  = ~data_bit_s;
      end
      S_STOP: begin
        case (qtr_d)
          2'd0:    begin scl_d = 1'b0; oe_d = 1'b1; end
          2'd1:    begin scl_d = 1'b1; oe_d = 1'b1; end
          default: begin scl_d = 1'b1; oe_d = 1'b0; end
        endcase
      end
      default: begin
        scl_d = 1'b1;
        oe_d  = 1'b0;
      end
    endcase
  end

  // State, counters, status and bus pin registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      qtr_q   <= 2'd0;
      cnt_q   <= {CW{1'b0}};
      bit_q   <= 4'd0;
      byte_q  <= 2'd0;
      idx_q   <= 3'd0;
      wcnt_q  <= {WW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      scl_q   <= 1'b1;
      oe_q    <= 1'b0;
`ifdef SCCB_ACK_CHECK_EN
      err_q   <= 1'b0;
      nack_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      qtr_q   <= qtr_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      scl_q   <= scl_d;
      oe_q    <= oe_d;
`ifdef SCCB_ACK_CHECK_EN
      err_q   <= err_d;
      nack_q  <= nack_d;
`endif
    end
  end

  assign sccb_scl    = scl_q;
  assign sccb_sda_oe = oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign reg_idx     = idx_q;

endmodule

// File: tb/tb_cam_sccb_config.sv
`timescale 1ns/1ps
module tb_cam_sccb_config;

  // Scaled timing: QTR = 1_600_000 / (4 * 100_000) = 4 cycles per quarter.
  localparam int unsigned QTR      = 4;
  localparam int unsigned WAIT_CYC = 100;
  localparam int unsigned TXN_CYC  = 480;   // 30 bit periods * 4 quarters * 4
  localparam int unsigned RUN_CYC  = 3940;  // 8 * 480 + 100

  localparam logic [15:0] TBL [0:7] = '{16'h1280, 16'h1204, 16'h1100, 16'h0C04,
                                        16'h3E1A, 16'h40D0, 16'h7222, 16'h73F2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sccb_scl;
  logic       sccb_sda_oe;
  logic       sccb_sda_in;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] reg_idx;
  logic       tb_pull = 1'b0;
  logic       nack_en = 1'b0;

  typedef struct packed {
    logic [1:0] n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
  } wr_t;

  wr_t exp_q[$];
  int  start_cyc[$];
  int  cyc = 0;
  int  nvec = 0;
  int  nerr = 0;
  int  nwrites = 0;
  int  done_rises = 0;

  assign sccb_sda_in = ~(sccb_sda_oe | tb_pull);

  cam_sccb_config #(
    .CLK_HZ(1_600_000),
    .SCCB_HZ(100_000),
    .DEV_ADDR(8'h42),
    .RESET_WAIT_CYC(WAIT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .sccb_scl(sccb_scl),
    .sccb_sda_oe(sccb_sda_oe),
    .sccb_sda_in(sccb_sda_in),
    .busy(busy),
    .done(done),
    .err(err),
    .reg_idx(reg_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_write(input int idx, input logic [1:0] n);
    wr_t w;
    w.n  = n;
    w.b0 = 8'h42;
    w.b1 = TBL[idx][15:8];
    w.b2 = TBL[idx][7:0];
    exp_q.push_back(w);
  endtask

  task automatic pulse_start(output int c0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input int bound);
    int t;
    t = 0;
    while (!done && t < bound) begin
      @(negedge clk);
      t++;
    end
  endtask

  // SCCB bus monitor / slave model: decodes writes and compares each against
  // the scoreboard queue at STOP.
  initial begin : monitor
    logic       scl_p, sda_p, sda, done_p, m_in;
    int         bits, nb;
    logic [7:0] sh;
    logic [7:0] got [0:2];
    wr_t        e;
    scl_p = 1'b1; sda_p = 1'b1; done_p = 1'b0; m_in = 1'b0;
    bits = 0; nb = 0; sh = 8'h00;
    got[0] = 8'h00; got[1] = 8'h00; got[2] = 8'h00;
    forever begin
      @(negedge clk);
      sda = ~(sccb_sda_oe | tb_pull);
      if (done === 1'b1 && done_p !== 1'b1) done_rises++;
      done_p = done;
      if (rst) begin
        m_in = 1'b0; bits = 0; nb = 0; tb_pull = 1'b0;
      end else if (scl_p && sccb_scl && sda_p && !sda) begin
        m_in = 1'b1; bits = 0; nb = 0;
        start_cyc.push_back(cyc);
      end else if (m_in && scl_p && sccb_scl && !sda_p && sda) begin
        m_in = 1'b0;
        nwrites++;
        if (exp_q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL extra_write: got %0d bytes %h %h %h, want no write", nb, got[0], got[1], got[2]);
        end else begin
          e = exp_q.pop_front();
          check("write_len", nb, {30'd0, e.n});
          check("write_dev", {24'd0, got[0]}, {24'd0, e.b0});
          check("write_reg", {24'd0, got[1]}, {24'd0, e.b1});
          if (e.n == 2'd3) check("write_val", {24'd0, got[2]}, {24'd0, e.b2});
        end
      end else if (m_in && !scl_p && sccb_scl) begin
        if (bits < 8) sh = {sh[6:0], sda};
        bits++;
        if (bits == 9) begin
          if (nb < 3) got[nb] = sh;
          nb++;
          bits = 0;
        end
      end else if (m_in && scl_p && !sccb_scl) begin
        // ACK in the 9th bit, except the reg byte 0x40 when NACK is requested.
        tb_pull = (bits == 8) && !(nack_en && nb == 1 && sh == 8'h40);
      end
      scl_p = sccb_scl;
      sda_p = sda;
    end
  end

  initial begin : stim
    int c0, w0, d0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_scl", sccb_scl, 1);
    check("rst_sda_oe", sccb_sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_reg_idx", reg_idx, 0);
    rst = 1'b0;
    @(negedge clk);

    // Run 1: full table, with an ignored start pulse mid-run.
    for (int i = 0; i < 8; i++) push_write(i, 2'd3);
    start_cyc.delete();
    w0 = nwrites; d0 = done_rises;
    pulse_start(c0);
    check("busy_after_start", busy, 1);
    check("done_low_in_run", done, 0);
    repeat (1500) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_ignored_start", busy, 1);
    wait_done(6000);
    check("done_seen", done, 1);
    check("done_cycle", cyc - c0, RUN_CYC);
    check("busy_at_done", busy, 0);
    check("start_events", start_cyc.size(), 8);
    if (start_cyc.size() >= 3) begin
      check("first_sda_fall", start_cyc[0] - c0, QTR);
      check("gap_after_reset_write", start_cyc[1] - start_cyc[0], TXN_CYC + WAIT_CYC);
      check("gap_entry_1_2", start_cyc[2] - start_cyc[1], TXN_CYC);
    end
    repeat (50) @(negedge clk);
    check("done_sticky", done, 1);
    check("err_run1", err, 0);
    check("writes_run1", nwrites - w0, 8);
    check("queue_empty_run1", exp_q.size(), 0);
    check("single_done", done_rises - d0, 1);

    // Run 2: reset in the middle of entry 3's first byte.
    for (int i = 0; i < 3; i++) push_write(i, 2'd3);
    w0 = nwrites;
    pulse_start(c0);
    check("done_cleared_on_start", done, 0);
    repeat (1620) @(negedge clk);
    check("reg_idx_before_rst", reg_idx, 3);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_scl", sccb_scl, 1);
    check("midrst_sda_oe", sccb_sda_oe, 0);
    check("midrst_busy", busy, 0);
    check("midrst_reg_idx", reg_idx, 0);
    @(negedge clk);
    rst = 1'b0;
    check("writes_before_rst", nwrites - w0, 3);
    check("queue_empty_rst", exp_q.size(), 0);

    // Replay after reset.
    for (int i = 0; i < 8; i++) push_write(i, 2'd3);
    w0 = nwrites;
    pulse_start(c0);
    wait_done(6000);
    check("replay_done_cycle", cyc - c0, RUN_CYC);
    check("replay_writes", nwrites - w0, 8);
    check("queue_empty_replay", exp_q.size(), 0);

    // Run 4: slave NACKs the reg byte of entry 5.
    nack_en = 1'b1;
    for (int i = 0; i < 5; i++) push_write(i, 2'd3);
    w0 = nwrites;
`ifdef SCCB_ACK_CHECK_EN
    push_write(5, 2'd2);
    pulse_start(c0);
    begin
      int t;
      t = 0;
      while (busy && t < 6000) begin
        @(negedge clk);
        t++;
      end
    end
    check("nack_busy", busy, 0);
    check("nack_err", err, 1);
    check("nack_done", done, 0);
    check("nack_reg_idx", reg_idx, 5);
    repeat (600) @(negedge clk);
    check("nack_writes", nwrites - w0, 6);
    check("nack_queue_empty", exp_q.size(), 0);
`else
    for (int i = 5; i < 8; i++) push_write(i, 2'd3);
    pulse_start(c0);
    wait_done(6000);
    check("nack_ignored_done", done, 1);
    check("nack_ignored_err", err, 0);
    check("nack_ignored_cycle", cyc - c0, RUN_CYC);
    repeat (50) @(negedge clk);
    check("nack_ignored_writes", nwrites - w0, 8);
    check("nack_ignored_queue", exp_q.size(), 0);
`endif
    nack_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
